uart_frame_ctrl: RTL
====================

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 15, maximum payload byte count (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  system clock; reset synchronous, active-high, sampled on the rising edge of clk.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port byte_valid  input  1  one-cycle strobe from the UART receiver marking a new byte.
REQ-007 SHALL have port byte_data  input  8  received byte; valid only while byte_valid=1.
REQ-008 SHALL have port pay_we  output  1  payload write strobe.
REQ-009 SHALL have port pay_addr  output  4  payload byte index (0-based).
REQ-010 SHALL have port pay_data  output  8  payload byte.
REQ-011 SHALL have port frame_cmd  output  8  command byte of the current/last frame.
REQ-012 SHALL have port frame_len  output  4  payload length of the current/last frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse: good frame received.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse: frame aborted.
REQ-015 SHALL have port err_code  output  2  abort cause, valid with frame_err: 01 length, 10 checksum, 11 timeout.
REQ-016 SHALL have port busy  output  1  high in every state except HUNT.

Function
REQ-017 Frame format SHALL be SYNC, CMD, LEN, LEN payload bytes, CHK.
REQ-018 CHK SHALL equal (CMD + LEN + sum of payload) mod 256, 8-bit wrap-around.
REQ-019 States SHALL be HUNT, CMD, LEN, PAYLOAD, CHK; state advances only on byte_valid or timeout.
REQ-020 HUNT: byte equal to SYNC_BYTE -> CMD; any other byte ignored, no output.
REQ-021 CMD: byte latched to frame_cmd, running sum initialised to the byte -> LEN.
REQ-022 LEN: byte > MAX_LEN -> frame_err, err_code=01, -> HUNT; LEN=0 -> CHK; else -> PAYLOAD, index cleared.
REQ-023 PAYLOAD: each byte -> pay_we=1, pay_addr=index, pay_data=byte; index increments; after byte LEN-1 -> CHK.
REQ-024 CHK: byte equals running sum -> frame_done; else frame_err, err_code=10; both -> HUNT.
REQ-025 All outputs SHALL be registered; response appears the cycle after the edge sampling byte_valid (latency 1).
REQ-026 pay_we, frame_done, frame_err SHALL each be high for exactly one cycle per event.
REQ-027 SYNC_BYTE value inside CMD/LEN/PAYLOAD/CHK SHALL be treated as data.
REQ-028 Idle counter SHALL clear on every byte_valid and on entry to HUNT; counts only while busy.
REQ-029 Counter reaching TIMEOUT_CYCLES-1 without byte_valid -> frame_err, err_code=11, -> HUNT.
REQ-030 byte_valid in the same cycle as timeout expiry SHALL win; byte processed, no timeout.
REQ-031 frame_cmd, frame_len SHALL hold until the next CMD/LEN byte.
REQ-032 Counter width SHALL be $clog2(TIMEOUT_CYCLES); no overflow.

Reset
REQ-033 reset SHALL force state HUNT, index 0, running sum 0, idle counter 0.
REQ-034 reset SHALL force all outputs to 0, including err_code=00 and busy=0.
REQ-035 reset mid-frame SHALL discard the frame with no frame_err pulse; byte_valid during reset is ignored.

Structure
REQ-036 State encodings, err_code constants and SYNC_BYTE default SHALL live in shared package uart_frame_pkg.
REQ-037 Idle timeout counter SHALL be sub-module uart_frame_timer (clear, run, expired).

Verification
REQ-038 Bytes A5 10 02 33 44 89 -> pay_we at addr0=33, addr1=44; frame_done once; frame_cmd=10; frame_len=2.
REQ-039 Bytes A5 10 02 33 44 88 -> two pay_we; frame_err, err_code=10; no frame_done.
REQ-040 Bytes A5 07 10 -> frame_err, err_code=01 after LEN; next A5 01 00 01 -> frame_done.
REQ-041 Bytes A5 20, then 50000 idle cycles -> frame_err, err_code=11; busy=0 after; byte at exact expiry cycle -> no error.
REQ-042 Bytes 00 FF A5 A5 01 A5 4B -> leading 00 FF ignored; payload addr0=A5; frame_done.
REQ-043 reset asserted after A5 10 02 33 -> busy=0, no pulses; following valid frame -> frame_done.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller: FSM state encodings,
// abort-cause codes, the default sync marker and the checksum helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Modulo-256 running checksum step.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Idle cycle counter; holds at LAST so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (run && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = run && (cnt_r == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Byte-stream frame parser: SYNC, CMD, LEN, payload, CHK. Streams payload
// bytes out as writes and reports good/aborted frames with one-cycle pulses.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = 15,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       pay_we,
    output logic [3:0] pay_addr,
    output logic [7:0] pay_data,
    output logic [7:0] frame_cmd,
    output logic [3:0] frame_len,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t state_r, state_s;
    logic [7:0]   sum_r, sum_s;
    logic [3:0]   idx_r, idx_s;
    logic [7:0]   frame_cmd_r, cmd_s;
    logic [3:0]   frame_len_r, len_s;
    logic         pay_we_r, pay_we_s;
    logic [3:0]   pay_addr_r, pay_addr_s;
    logic [7:0]   pay_data_r, pay_data_s;
    logic         frame_done_r, done_s;
    logic         frame_err_r, err_s;
    logic [1:0]   err_code_r, code_s;
    logic         busy_r;
    logic         expired_s;
    logic         timer_clear_s;
    logic         timer_run_s;

    // The counter restarts on every byte and is held clear while hunting.
    assign timer_clear_s = byte_valid || (state_r == ST_HUNT);
    assign timer_run_s   = (state_r != ST_HUNT);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expired(expired_s)
    );

    // Next-state and next-output decode; a byte arriving at expiry beats the timeout.
    always_comb begin
        state_s    = state_r;
        sum_s      = sum_r;
        idx_s      = idx_r;
        cmd_s      = frame_cmd_r;
        len_s      = frame_len_r;
        pay_we_s   = 1'b0;
        pay_addr_s = pay_addr_r;
        pay_data_s = pay_data_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        code_s     = err_code_r;
        if (byte_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_s = ST_CMD;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_CMD: begin
                    cmd_s   = byte_data;
                    sum_s   = byte_data;
                    state_s = ST_LEN;
                end
                ST_LEN: begin
                    if (byte_data > MAX_LEN_B) begin
                        err_s   = 1'b1;
                        code_s  = ERR_LEN;
                        state_s = ST_HUNT;
                    end else begin
                        len_s = byte_data[3:0];
                        sum_s = chk_add(sum_r, byte_data);
                        idx_s = 4'd0;
                        if (byte_data == 8'd0) begin
                            state_s = ST_CHK;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    pay_we_s   = 1'b1;
                    pay_addr_s = idx_r;
                    pay_data_s = byte_data;
                    sum_s      = chk_add(sum_r, byte_data);
                    idx_s      = idx_r + 4'd1;
                    if (idx_r == (frame_len_r - 4'd1)) begin
                        state_s = ST_CHK;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
                ST_CHK: begin
                    if (byte_data == sum_r) begin
                        done_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                        code_s = ERR_CHK;
                    end
                    state_s = ST_HUNT;
                end
                default: begin
                    state_s = ST_HUNT;
                end
            endcase
        end else if (expired_s) begin
            err_s   = 1'b1;
            code_s  = ERR_TIMEOUT;
            state_s = ST_HUNT;
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_HUNT;
            sum_r        <= 8'd0;
            idx_r        <= 4'd0;
            frame_cmd_r  <= 8'd0;
            frame_len_r  <= 4'd0;
            pay_we_r     <= 1'b0;
            pay_addr_r   <= 4'd0;
            pay_data_r   <= 8'd0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sum_r        <= sum_s;
            idx_r        <= idx_s;
            frame_cmd_r  <= cmd_s;
            frame_len_r  <= len_s;
            pay_we_r     <= pay_we_s;
            pay_addr_r   <= pay_addr_s;
            pay_data_r   <= pay_data_s;
            frame_done_r <= done_s;
            frame_err_r  <= err_s;
            err_code_r   <= code_s;
            busy_r       <= (state_s != ST_HUNT);
        end
    end

    assign pay_we     = pay_we_r;
    assign pay_addr   = pay_addr_r;
    assign pay_data   = pay_data_r;
    assign frame_cmd  = frame_cmd_r;
    assign frame_len  = frame_len_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign err_code   = err_code_r;
    assign busy       = busy_r;

endmodule
